// File: rtl/cla_seq_adder_ctrl.sv
//==============================================================================
// Module  : cla_seq_adder_ctrl
// Brief   : Adds WIDTH-bit operands one nibble per cycle on a single shared
//           4-bit CLA slice, with valid/ready handshakes on both sides.
//           Optional subtract mode: define CLA_SEQ_ADDSUB_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_seq_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = o_gg | (o_pg & i_c);

  assign o_pg   = &w_p;
  assign o_gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SEQ_ADDSUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic             r_busy;

  logic [WIDTH-1:0] w_b_eff;
  logic [IDXW+1:0]  w_base;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_unused_pg;
  logic             w_unused_gg;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_ovf;
  logic             w_init_carry;

`ifdef CLA_SEQ_ADDSUB_EN
  logic r_sub;
  assign w_b_eff      = r_sub ? ~r_b : r_b;
  assign w_init_carry = in_sub | in_cin;
`else
  assign w_b_eff      = r_b;
  assign w_init_carry = in_cin;
`endif

  assign w_base = {r_idx, 2'b00};
  assign w_last = (r_idx == IDXW'(NSLICE - 1));

  cla_seq_cla4 u_cla (
    .i_a    (r_a[w_base +: 4]),
    .i_b    (w_b_eff[w_base +: 4]),
    .i_c    (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_pg   (w_unused_pg),
    .o_gg   (w_unused_gg)
  );

  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[w_base +: 4] = w_slice_sum;
  end

  // Only meaningful on the last slice, where w_slice_sum[3] is the result MSB.
  assign w_ovf = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_slice_sum[3] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CLA_SEQ_ADDSUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_carry    <= w_init_carry;
`ifdef CLA_SEQ_ADDSUB_EN
            r_sub      <= in_sub;
`endif
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_next;
            r_out_cout  <= w_slice_cout;
            r_out_ovf   <= w_ovf;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign busy      = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl: directed cases plus random
// operations compared against an arithmetic reference model.
`default_nettype none

module tb_cla_seq_adder_ctrl;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SEQ_ADDSUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int bp);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] es;
    logic             ec, eo;
    int               edges;
    // Reference: signed/unsigned arithmetic on the whole words.
    if (sub) begin
      es = a - b;
      ec = (a >= b);
      eo = (a[WIDTH-1] != b[WIDTH-1]) && (es[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      es = full[WIDTH-1:0];
      ec = full[WIDTH];
      eo = (a[WIDTH-1] == b[WIDTH-1]) && (es[WIDTH-1] != a[WIDTH-1]);
    end

    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      in_cin = 1'($urandom); in_sub = 1'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency", edges, NSLICE + 1);
    chk("sum", out_sum, es);
    chk("cout", out_cout, ec);
    chk("ovf", out_ovf, eo);
    chk("in_ready_done", in_ready, 0);
    chk("busy_done", busy, 1);

    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      in_cin = 1'($urandom); in_sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, es);
      chk("bp_flags", {out_cout, out_ovf}, {ec, eo});
      chk("bp_in_ready", in_ready, 0);
    end

    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_sum_hold", out_sum, es);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rsub;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_flags", {out_cout, out_ovf}, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 3);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 0);

    // Abort during the second RUN cycle.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy_clr", busy, 0);
    chk("abort_sum", out_sum, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_ADDSUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
`endif

    for (int n = 0; n < 25; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 5 == 0) ra = 16'hFFFF;
      if (n % 7 == 0) rb = 16'h8000;
`ifdef CLA_SEQ_ADDSUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom), rsub, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Sequencing controller that adds WIDTH-bit operands using one shared 4-bit cla slice over several cycles, one nibble per cycle, least-significant nibble first.
- Carry is chained between cycles through a register.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Trades latency for area wherever a wide adder is needed infrequently.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived localparam; number of nibble cycles per operation.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in of the operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  carry-out of bit WIDTH-1.
- out_ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0. All operand, carry and index registers are cleared.
- The controller instantiates exactly one 4-bit cla.
  - Slice inputs: a_reg[4*idx+:4], b_eff[4*idx+:4] and carry_reg.
  - The slice's pg/gg outputs are unused.
- IDLE state:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: capture in_a, in_b and in_cin into a_reg, b_reg and carry_reg; set idx=0; go to RUN.
- RUN state:
  - in_ready=0.
  - Each cycle, the slice sum is written into sum_reg[4*idx+:4] and carry_reg<=slice c_out.
  - If idx==NSLICE-1, go to DONE and register cout/ovf. Otherwise idx<=idx+1.
- DONE state:
  - out_valid=1.
  - out_sum=sum_reg, out_cout=carry_reg.
  - out_ovf=(a_msb==b_eff_msb)&&(sum_msb!=a_msb).
  - On out_ready go to IDLE, with out_valid=0 the following cycle.
- Latency: out_valid rises exactly NSLICE+1 clock edges after the accept edge. The accept edge, NSLICE RUN edges, then DONE visible. For WIDTH=16, out_valid is high after the 5th edge counting the accept edge.
- Throughput: one operation at a time. No new operand is accepted before the DONE handshake completes.
- Backpressure:
  - While out_valid&&!out_ready, out_sum, out_cout and out_ovf hold stable.
  - in_valid is ignored in this condition (in_ready=0).
- Inputs are sampled only at the accept edge. Changes on in_a, in_b and in_cin during RUN have no effect.
- out_sum is valid only when out_valid=1. Partial results may be visible internally but are not driven out until DONE; out_sum holds the last value otherwise.
- Carry propagates across all nibble boundaries. Wrap-around is modulo 2^WIDTH, with the overflow bit reported on out_cout.
- Reset asserted in any state, including mid-RUN:
  - The operation aborts immediately and all outputs return to reset values.
  - No result is produced for the aborted operation.
  - After release, the block is in IDLE with in_ready=1.
- The accept and DONE handshakes never coincide, since in_ready=0 in DONE. Simultaneous in_valid and out_ready in DONE therefore completes the output only.

Optional Feature:
- Macro: CLA_SEQ_ADDSUB_EN.
- When defined:
  - Adds input port in_sub (1 bit), captured at the accept edge.
  - If in_sub=1: b_eff=~b_reg and the initial carry_reg=1 (in_cin ignored), giving A-B.
  - If in_sub=0: b_eff=b_reg with the normal in_cin.
  - out_ovf uses b_eff.
- When undefined:
  - The in_sub port is absent and b_eff=b_reg (add only).
  - No subtract logic is synthesised.

Test Plan:
- WIDTH=16, in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_cout=0, out_ovf=0; out_valid high exactly 5 edges after accept (counting the accept edge).
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0 (carry ripples through all 4 nibble cycles). Then in_a=0x0000, in_b=0x0000, in_cin=1 -> out_sum=0x0001.
- in_a=0x7FFF, in_b=0x0001 -> out_sum=0x8000, out_cout=0, out_ovf=1. Then in_a=0x8000, in_b=0x8000 -> out_sum=0x0000, out_cout=1, out_ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands -> out_valid stays 1, outputs stable, in_ready=0, new operands not accepted. out_ready=1 -> IDLE, then the next operation is accepted normally.
- Drive rst_n=0 during the 2nd RUN cycle -> all outputs 0 immediately, out_valid never rises for that operation. After release, 0x00FF+0x0001 -> 0x0100.
- With CLA_SEQ_ADDSUB_EN: in_sub=1, 0x0005-0x0007 -> out_sum=0xFFFE, out_cout=0, out_ovf=0. Then in_sub=1, 0x8000-0x0001 -> out_sum=0x7FFF, out_cout=1, out_ovf=1.
